// File: rtl/sat_narrower_18_to_10.sv
// Narrows signed IN_W-bit samples to OUT_W bits (saturate or wrap) behind a
// one-deep valid/ready output register, with sticky and counted overflow stats.
module sat_narrower_18_to_10 #(
  parameter int IN_W     = 18,
  parameter int OUT_W    = 10,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_stats
);

  logic [IN_W-OUT_W:0] w_hi;
  logic                w_ovf;
  logic                w_accept;
  logic [OUT_W-1:0]    w_narrow;

  logic                r_out_valid;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_ovf;
  logic                r_sticky;
  logic [CNT_W-1:0]    r_count;

  // The value fits only when every bit from the MSB down to the OUT_W sign bit agrees.
  assign w_hi  = in_data[IN_W-1:OUT_W-1];
  assign w_ovf = ~((&w_hi) | ~(|w_hi));

  generate
    if (SATURATE != 0) begin : g_sat
      assign w_narrow = !w_ovf          ? in_data[OUT_W-1:0] :
                        in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                          {1'b0, {(OUT_W-1){1'b1}}};
    end else begin : g_wrap
      assign w_narrow = in_data[OUT_W-1:0];
    end
  endgenerate

  assign in_ready = rst_n & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_narrow;
      r_out_ovf   <= w_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A clear wins over an overflow arriving in the same cycle; that event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (clr_stats) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (w_accept && w_ovf) begin
      r_sticky <= 1'b1;
      if (!(&r_count)) begin
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ovf    = r_out_ovf;
  assign ovf_sticky = r_sticky;
  assign ovf_count  = r_count;

endmodule

// File: doc/sat_narrower_18_to_10.md
Name: sat_narrower_18_to_10

Overview:
Converts a stream of 18-bit two's-complement samples back to 10-bit signed values. It is the return path for 10→18 sign-extended data after arithmetic in the wide domain. Overflow is handled by saturation, or by wrap when configured. The block registers its output behind a valid/ready handshake and keeps overflow statistics (sticky flag plus saturating counter) for the datapath controller.

Parameters:
IN_W, 18, input sample width (signed).
OUT_W, 10, output sample width (signed); must satisfy OUT_W < IN_W.
SATURATE, 1, 1 = clamp out-of-range values to the nearest representable value; 0 = wrap (keep low OUT_W bits).
CNT_W, 16, width of the overflow event counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block can accept a sample this cycle.
in_data  input  IN_W  signed input sample.
out_valid  output  1  out_data holds a valid sample.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  OUT_W  narrowed signed sample.
out_ovf  output  1  the sample in out_data overflowed the OUT_W range.
ovf_sticky  output  1  set by any accepted overflowing sample since reset or clear.
ovf_count  output  CNT_W  number of accepted overflowing samples, saturating.
clr_stats  input  1  synchronous clear of ovf_sticky and ovf_count.

Behaviour:
- Reset (rst_n low, asynchronous assertion): out_valid=0, out_data=0, out_ovf=0, ovf_sticky=0, ovf_count=0. While reset is asserted, in_ready=0. Reset mid-transfer discards the held sample and nothing is replayed.
- Single output register (pipeline stage), latency 1 cycle, full throughput.
- in_ready = !out_valid || out_ready. This is combinational and has no dependence on in_valid.
- Accept condition: in_valid && in_ready. On accept, at the next edge: out_data <= narrow(in_data), out_ovf <= ovf(in_data), out_valid <= 1.
- No accept, but out_valid && out_ready: out_valid <= 0. out_data and out_ovf hold their last values.
- No accept and out_ready=0: out_valid, out_data and out_ovf hold. in_data is don't-care when in_valid=0.
- Overflow detect: ovf = in_data[IN_W-1:OUT_W-1] not all equal, i.e. the value lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1] = [-512, 511].
- narrow(), no overflow: in_data[OUT_W-1:0] (exact).
- narrow(), overflow with SATURATE=1: positive (in_data MSB=0) gives 0x1FF (+511); negative gives 0x200 (-512).
- narrow(), overflow with SATURATE=0: in_data[OUT_W-1:0]. out_ovf is still flagged.
- Statistics update only on an accepted sample with ovf=1:
  - ovf_sticky <= 1.
  - ovf_count <= ovf_count+1, holding at all-ones (2^CNT_W-1) with no wrap.
- clr_stats=1: ovf_sticky <= 0 and ovf_count <= 0 at the next edge. Clear has priority over a same-cycle overflow increment; that event is not counted and does not set the sticky flag.
- clr_stats does not affect out_valid, out_data or out_ovf.
- No combinational path from in_data to any output. out_valid, out_data and out_ovf must remain stable while out_valid=1 && out_ready=0 (standard AXI-style hold rule).

Test Plan:
- Exact range, SATURATE=1, out_ready=1: in_data 0x001FF, 0x3FE00, 0x00000 -> out_data 0x1FF, 0x200, 0x000, each with out_ovf=0, one cycle after accept; ovf_count stays 0.
- Saturation boundaries: 0x00200 (+512) -> 0x1FF with out_ovf=1; 0x3FDFF (-513) -> 0x200 with out_ovf=1; 0x1FFFF -> 0x1FF with ovf=1; 0x20000 -> 0x200 with ovf=1. Afterwards ovf_count=4 and ovf_sticky=1.
- Wrap mode (SATURATE=0): 0x00200 -> 0x200 with ovf=1; 0x00601 -> 0x201 with ovf=1; 0x3FFFF -> 0x3FF with ovf=0.
- Backpressure: stream 0x00005, 0x00006, 0x00007 back-to-back with out_ready=0 for 3 cycles then 1. Expect in_ready=0 while out_valid=1 and out_ready=0, out_data held at 0x005, then 0x005, 0x006, 0x007 delivered in order with no loss or duplication.
- Stats edge cases, CNT_W=4: 20 overflowing samples -> ovf_count=15 (holds). Assert clr_stats in the same cycle as an overflowing accept -> count=0 and sticky=0 next cycle; the following overflow gives count=1.
- Reset mid-operation: assert rst_n=0 asynchronously while out_valid=1 and out_ready=0 -> out_valid, out_data and stats are 0 immediately (before the next clk edge). After release, in_ready=1 and the first accepted sample appears normally.
